// File: rtl/ws_pkg.sv
// Shared constants for the weight-stationary processing element.
// Default widths and the helpers that give saturation bounds for a signed width.
package ws_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_FRAC  = 6;
  localparam int DEF_CNT_W = 16;

  // Saturation bounds for the default width.
  localparam longint WS_SAT_MAX = (64'sd1 <<< (DEF_DW - 1)) - 64'sd1;
  localparam longint WS_SAT_MIN = -(64'sd1 <<< (DEF_DW - 1));

  // Largest value representable in a signed field of width dw.
  function automatic longint ws_sat_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of width dw.
  function automatic longint ws_sat_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/ws_mul.sv
// Signed DW x DW multiplier with zero skip.
// When either operand is zero the product is forced to zero and 'skip' is raised.
// Downstream logic uses 'skip' to leave the activity counter alone.
module ws_mul
  import ws_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] product,
  output logic                   skip
);

  localparam int PW = 2 * DW;

  // Both operands are sign-extended first, so the full-width product is exact.
  always_comb begin
    skip    = (a == '0) || (b == '0);
    product = skip ? '0 : (PW'(a) * PW'(b));
  end

endmodule

// File: rtl/ws_pe_pipe.sv
// Weight-stationary PE. It has a double-buffered weight and a two-stage MAC pipeline.
// The activation is forwarded to the neighbour PE.
// Optional feature: define WS_PE_SAT_EN to saturate the S2 result instead of wrapping it.
module ws_pe_pipe
  import ws_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int FRAC  = DEF_FRAC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 enable,
  input  logic                 w_valid,
  input  logic signed [DW-1:0] w_in,
  output logic                 w_ready,
  input  logic                 w_swap,
  input  logic                 x_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] psum_in,
  output logic                 psum_valid,
  output logic signed [DW-1:0] psum_out,
  output logic                 x_fwd_valid,
  output logic signed [DW-1:0] x_fwd,
  output logic [CNT_W-1:0]     mac_cnt
);

  localparam int PW = 2 * DW;

  logic signed [DW-1:0] active_w;
  logic signed [DW-1:0] shadow_w;
  logic                 shadow_full;
  logic                 w_load;
  logic                 w_do_swap;

  logic signed [PW-1:0] mul_prod;
  logic                 mul_skip;

  logic                 s1_valid;
  logic signed [PW-1:0] s1_prod;
  logic signed [DW-1:0] s1_psum;
  logic signed [DW-1:0] s2_result;

  // Loads are refused while the shadow is occupied. This also makes a load and a swap in the same cycle mutually exclusive.
  assign w_ready   = sys_rst_n && enable && !shadow_full;
  assign w_load    = w_valid && w_ready;
  assign w_do_swap = enable && w_swap && shadow_full;

  // Shadow and active weight registers. A swap reaches the multiplier on the next cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      active_w    <= '0;
      shadow_w    <= '0;
      shadow_full <= 1'b0;
    end else if (w_do_swap) begin
      active_w    <= shadow_w;
      shadow_full <= 1'b0;
    end else if (w_load) begin
      shadow_w    <= w_in;
      shadow_full <= 1'b1;
    end
  end

  ws_mul #(.DW(DW)) u_mul (
    .a       (x_in),
    .b       (active_w),
    .product (mul_prod),
    .skip    (mul_skip)
  );

  // Stage 1 captures the product and the incoming psum. The activation is forwarded to the neighbour in the same stage.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_valid    <= 1'b0;
      s1_prod     <= '0;
      s1_psum     <= '0;
      x_fwd_valid <= 1'b0;
      x_fwd       <= '0;
    end else if (enable) begin
      s1_valid    <= x_valid;
      x_fwd_valid <= x_valid;
      x_fwd       <= x_in;
      if (x_valid) begin
        s1_prod <= mul_prod;
        s1_psum <= psum_in;
      end
    end
  end

  // Count every MAC that is not skipped as it enters stage 1. The count sticks at all-ones.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mac_cnt <= '0;
    end else if (enable && x_valid && !mul_skip && (mac_cnt != '1)) begin
      mac_cnt <= mac_cnt + CNT_W'(1);
    end
  end

`ifdef WS_PE_SAT_EN
  localparam int SUM_W = PW + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(ws_sat_max(DW));
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(ws_sat_min(DW));

  logic signed [SUM_W-1:0] sum_full;

  // Keep the full-precision sum, then clamp it into the signed DW range.
  always_comb begin
    sum_full = SUM_W'(s1_prod >>> FRAC) + SUM_W'(s1_psum);
    if (sum_full > SAT_HI) begin
      s2_result = SAT_HI[DW-1:0];
    end else if (sum_full < SAT_LO) begin
      s2_result = SAT_LO[DW-1:0];
    end else begin
      s2_result = sum_full[DW-1:0];
    end
  end
`else
  // Wrapping arithmetic: only the low DW bits of the sum are kept.
  always_comb begin
    s2_result = DW'(s1_prod >>> FRAC) + s1_psum;
  end
`endif

  // Stage 2 registers the reduced sum and its valid flag.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      psum_valid <= 1'b0;
      psum_out   <= '0;
    end else if (enable) begin
      psum_valid <= s1_valid;
      if (s1_valid) begin
        psum_out <= s2_result;
      end
    end
  end

endmodule
